// File: rtl/pea_pkg.sv
// Shared types and constants for the streaming PEA functional units.
package pea_pkg;

    localparam int unsigned PEA_N_BITS = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    // Special-case quotients at the array datapath width
    localparam logic [PEA_N_BITS-1:0] DIV_ZERO_Q = '1;
    localparam logic [PEA_N_BITS-1:0] DIV_OVF_Q  = {1'b1, {(PEA_N_BITS-1){1'b0}}};

endpackage

// File: rtl/s_div_unit_if.sv
// Request/response port between the PE operand muxes and the divider FU.
interface s_div_unit_if #(
    parameter int unsigned N_BITS = 32
);
    logic              ops_valid_i;
    logic              signed_i;
    logic              sel_rem_i;
    logic [N_BITS-1:0] dividend_i;
    logic [N_BITS-1:0] divisor_i;
    logic              pea_ready_i;
    logic              ready_o;
    logic              valid_o;
    logic [N_BITS-1:0] res_o;
    logic [N_BITS-1:0] rem_q_o;

    modport master (
        output ops_valid_i, signed_i, sel_rem_i, dividend_i, divisor_i, pea_ready_i,
        input  ready_o, valid_o, res_o, rem_q_o
    );

    modport slave (
        input  ops_valid_i, signed_i, sel_rem_i, dividend_i, divisor_i, pea_ready_i,
        output ready_o, valid_o, res_o, rem_q_o
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, dvd} left and conditionally subtract.
module div_step #(
    parameter int unsigned N_BITS = 32
) (
    input  logic [N_BITS-1:0] rem,
    input  logic [N_BITS-1:0] dvd,
    input  logic [N_BITS-1:0] divisor,
    output logic [N_BITS-1:0] rem_next,
    output logic [N_BITS-1:0] dvd_next,
    output logic              q_bit
);
    logic [N_BITS:0] rem_sh;
    logic [N_BITS:0] diff;

    assign rem_sh = {rem, dvd[N_BITS-1]};
    assign diff   = rem_sh - {1'b0, divisor};

    // rem < divisor holds on entry, so the N_BITS+1 result's MSB is a clean borrow flag
    assign q_bit    = ~diff[N_BITS];
    assign rem_next = q_bit ? diff[N_BITS-1:0] : rem_sh[N_BITS-1:0];
    assign dvd_next = {dvd[N_BITS-2:0], q_bit};
endmodule

// File: rtl/s_div_unit.sv
// Iterative radix-2 signed/unsigned divider FU with valid/ready result hand-off.
module s_div_unit
    import pea_pkg::*;
#(
    parameter int unsigned N_BITS = 32,
    parameter int unsigned CNT_W  = $clog2(N_BITS) + 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         flush_i,
    s_div_unit_if.slave  bus
);
    localparam logic [N_BITS-1:0] ALL_ONES = '1;
    localparam logic [N_BITS-1:0] MIN_VAL  = {1'b1, {(N_BITS-1){1'b0}}};

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [N_BITS-1:0] rem_r, dvd_r, dsr_r;
    logic [N_BITS-1:0] res_r, sec_r;
    logic              sel_rem_r, neg_q_r, neg_r_r;

    logic              accept_c, last_c, div_zero_c, ovf_c, special_c;
    logic              a_neg_c, b_neg_c;
    logic [N_BITS-1:0] a_abs_c, b_abs_c, q_fix_c, r_fix_c;
    logic [N_BITS-1:0] rem_step, dvd_step;
    logic              q_bit_step;

    assign a_neg_c    = bus.signed_i & bus.dividend_i[N_BITS-1];
    assign b_neg_c    = bus.signed_i & bus.divisor_i[N_BITS-1];
    assign a_abs_c    = a_neg_c ? -bus.dividend_i : bus.dividend_i;
    assign b_abs_c    = b_neg_c ? -bus.divisor_i  : bus.divisor_i;
    assign div_zero_c = (bus.divisor_i == '0);
    assign ovf_c      = bus.signed_i & (bus.dividend_i == MIN_VAL) & (bus.divisor_i == ALL_ONES);
    assign special_c  = div_zero_c | ovf_c;
    assign accept_c   = (state_q == DIV_IDLE) & bus.ops_valid_i & ~flush_i;
    assign last_c     = (cnt_q == CNT_W'(N_BITS - 1));

    assign q_fix_c = neg_q_r ? -dvd_r : dvd_r;
    assign r_fix_c = neg_r_r ? -rem_r : rem_r;

    div_step #(.N_BITS(N_BITS)) u_step (
        .rem      (rem_r),
        .dvd      (dvd_r),
        .divisor  (dsr_r),
        .rem_next (rem_step),
        .dvd_next (dvd_step),
        .q_bit    (q_bit_step)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= DIV_IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode; flush overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (bus.ops_valid_i) state_d = special_c ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (last_c)          state_d = DIV_FIX;
            DIV_FIX:                       state_d = DIV_DONE;
            DIV_DONE: if (bus.pea_ready_i) state_d = DIV_IDLE;
            default:                       state_d = DIV_IDLE;
        endcase
        if (flush_i) state_d = DIV_IDLE;
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            rem_r     <= '0;
            dvd_r     <= '0;
            dsr_r     <= '0;
            res_r     <= '0;
            sec_r     <= '0;
            sel_rem_r <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
        end else if (accept_c) begin
            cnt_q     <= '0;
            rem_r     <= '0;
            dvd_r     <= a_abs_c;
            dsr_r     <= b_abs_c;
            sel_rem_r <= bus.sel_rem_i;
            neg_q_r   <= a_neg_c ^ b_neg_c;
            neg_r_r   <= a_neg_c;
            if (div_zero_c) begin
                res_r <= bus.sel_rem_i ? bus.dividend_i : ALL_ONES;
                sec_r <= bus.sel_rem_i ? ALL_ONES : bus.dividend_i;
            end else if (ovf_c) begin
                res_r <= bus.sel_rem_i ? '0 : MIN_VAL;
                sec_r <= bus.sel_rem_i ? MIN_VAL : '0;
            end
        end else if (!flush_i && state_q == DIV_CALC) begin
            rem_r <= rem_step;
            dvd_r <= dvd_step;
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (!flush_i && state_q == DIV_FIX) begin
            res_r <= sel_rem_r ? r_fix_c : q_fix_c;
            sec_r <= sel_rem_r ? q_fix_c : r_fix_c;
        end
    end

    assign bus.ready_o = (state_q == DIV_IDLE);
    assign bus.valid_o = (state_q == DIV_DONE);
    assign bus.res_o   = res_r;
    assign bus.rem_q_o = sec_r;

    logic unused_c;
    assign unused_c = q_bit_step;
endmodule

// File: tb/tb_s_div_unit.sv
// Directed self-checking bench for the s_div_unit divider FU (N_BITS=32).
module tb_s_div_unit;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    s_div_unit_if #(.N_BITS(32)) bus ();

    s_div_unit #(.N_BITS(32)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, presents one operand pair for one cycle
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic sg, input logic sl);
        int w = 0;
        while (!bus.ready_o && w < 200) begin
            step_cyc();
            w++;
        end
        bus.dividend_i  = a;
        bus.divisor_i   = b;
        bus.signed_i    = sg;
        bus.sel_rem_i   = sl;
        bus.ops_valid_i = 1'b1;
        step_cyc();
        bus.ops_valid_i = 1'b0;
    endtask

    // Cycle index (accept cycle = 0) at which valid_o is first seen
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.valid_o && lat < 100) begin
            step_cyc();
            lat++;
        end
    endtask

    task automatic release_result();
        bus.pea_ready_i = 1'b1;
        step_cyc();
        bus.pea_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.ops_valid_i = 1'b0; bus.signed_i = 1'b0; bus.sel_rem_i = 1'b0;
        bus.dividend_i = '0; bus.divisor_i = '0; bus.pea_ready_i = 1'b0;
        step_cyc();
        step_cyc();
        n_checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: ready=%b valid=%b expected ready=1 valid=0", bus.ready_o, bus.valid_o);
        end
        n_checks++;
        if (bus.res_o !== 32'h0 || bus.rem_q_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: res=%h rem_q=%h expected 0/0", bus.res_o, bus.rem_q_o);
        end
        rst_n = 1'b1;
        step_cyc();
    endtask

    task automatic run_table(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic sg, input logic sl, input logic [31:0] e_res,
                             input logic [31:0] e_sec, input int e_lat);
        int lat;
        start_op(a, b, sg, sl);
        wait_valid(lat);
        n_checks++;
        if (lat !== e_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, e_lat);
        end
        n_checks++;
        if (bus.res_o !== e_res || bus.rem_q_o !== e_sec) begin
            n_fail++;
            $display("FAIL %s_result: res=%h rem_q=%h expected %h/%h", name, bus.res_o, bus.rem_q_o, e_res, e_sec);
        end
        release_result();
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release: valid=%b ready=%b expected 0/1", name, bus.valid_o, bus.ready_o);
        end
    endtask

    task automatic test_normal();
        run_table("u_100_7",    32'd100,       32'd7,         1'b0, 1'b0, 32'd14,        32'd2,         34);
        run_table("s_m7_2_rem", 32'hFFFFFFF9,  32'd2,         1'b1, 1'b1, 32'hFFFFFFFF,  32'hFFFFFFFD,  34);
        run_table("s_7_m2",     32'd7,         32'hFFFFFFFE,  1'b1, 1'b0, 32'hFFFFFFFD,  32'd1,         34);
        run_table("s_m7_m2",    32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, 1'b0, 32'd3,         32'hFFFFFFFF,  34);
        run_table("u_small",    32'd5,         32'd9,         1'b0, 1'b0, 32'd0,         32'd5,         34);
        run_table("u_max_16",   32'hFFFFFFFF,  32'h10,        1'b0, 1'b1, 32'hF,         32'h0FFFFFFF,  34);
        run_table("u_min_max",  32'h80000000,  32'hFFFFFFFF,  1'b0, 1'b0, 32'd0,         32'h80000000,  34);
    endtask

    task automatic test_special();
        run_table("u_div0",     32'd5,         32'd0,         1'b0, 1'b0, 32'hFFFFFFFF,  32'd5,         1);
        run_table("s_div0",     32'hFFFFFFFB,  32'd0,         1'b1, 1'b0, 32'hFFFFFFFF,  32'hFFFFFFFB,  1);
        run_table("u_div0_rem", 32'd5,         32'd0,         1'b0, 1'b1, 32'd5,         32'hFFFFFFFF,  1);
        run_table("s_ovf",      32'h80000000,  32'hFFFFFFFF,  1'b1, 1'b0, 32'h80000000,  32'd0,         1);
    endtask

    task automatic test_stall();
        int lat;
        start_op(32'd100, 32'd7, 1'b0, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            bus.dividend_i  = 32'(i + 50);
            bus.divisor_i   = 32'd3;
            bus.ops_valid_i = 1'b1;
            step_cyc();
            n_checks++;
            if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 ||
                bus.res_o !== 32'd14 || bus.rem_q_o !== 32'd2) begin
                n_fail++;
                $display("FAIL stall_hold%0d: valid=%b ready=%b res=%h rem_q=%h expected 1/0/0000000e/00000002",
                         i, bus.valid_o, bus.ready_o, bus.res_o, bus.rem_q_o);
            end
        end
        bus.ops_valid_i = 1'b0;
        release_result();
        n_checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.res_o !== 32'd14) begin
            n_fail++;
            $display("FAIL stall_release: ready=%b valid=%b res=%h expected 1/0/0000000e",
                     bus.ready_o, bus.valid_o, bus.res_o);
        end
    endtask

    task automatic test_flush();
        start_op(32'd1000, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step_cyc();
        n_checks++;
        if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL calc_busy: ready=%b valid=%b expected 0/0", bus.ready_o, bus.valid_o);
        end
        flush = 1'b1;
        step_cyc();
        flush = 1'b0;
        n_checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 ||
            bus.res_o !== 32'd14 || bus.rem_q_o !== 32'd2) begin
            n_fail++;
            $display("FAIL flush_abort: ready=%b valid=%b res=%h rem_q=%h expected 1/0/0000000e/00000002",
                     bus.ready_o, bus.valid_o, bus.res_o, bus.rem_q_o);
        end
        for (int i = 0; i < 40; i++) step_cyc();
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.res_o !== 32'd14) begin
            n_fail++;
            $display("FAIL flush_no_result: valid=%b res=%h expected 0/0000000e", bus.valid_o, bus.res_o);
        end
    endtask

    task automatic test_reset_mid();
        start_op(32'd1000, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step_cyc();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 ||
            bus.res_o !== 32'h0 || bus.rem_q_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: ready=%b valid=%b res=%h rem_q=%h expected 1/0/0/0",
                     bus.ready_o, bus.valid_o, bus.res_o, bus.rem_q_o);
        end
        #3 rst_n = 1'b1;
        step_cyc();
        run_table("post_rst", 32'd1000, 32'd3, 1'b0, 1'b0, 32'd333, 32'd1, 34);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/s_div_unit.md
# s_div_unit

Iterative radix-2 divider acting as the responder to a streaming PE's functional-unit request port. It accepts one operand pair per handshake and computes quotient and remainder over N_BITS cycles, signed or unsigned. It returns both results under valid/ready, honouring the PEA-wide stall `pea_ready_i`. It sits inside the divider FU wrapper of the streaming PEA, between the PE operand muxes and the PE output/delay registers.

## Interface
- `N_BITS`, default 32: operand and result width.
- `CNT_W`, default `$clog2(N_BITS)+1`: iteration counter width.

Ports:
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous abort to IDLE.
- `ops_valid_i`  in  1  operand pair valid.
- `signed_i`  in  1  1 = signed division, 0 = unsigned.
- `sel_rem_i`  in  1  1 = `res_o` carries the remainder and `rem_q_o` the quotient; 0 = the reverse.
- `dividend_i`  in  N_BITS  dividend.
- `divisor_i`  in  N_BITS  divisor.
- `pea_ready_i`  in  1  downstream/array ready; consumes the result.
- `ready_o`  out  1  unit can accept operands.
- `valid_o`  out  1  result valid.
- `res_o`  out  N_BITS  primary result.
- `rem_q_o`  out  N_BITS  secondary result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - `ready_o`=1.
  - `ops_valid_i`=1 accepts: latch `signed_i`, `sel_rem_i`, the operand signs and the operand magnitudes (absolute values when `signed_i`=1).
  - If divisor==0 or signed overflow, go to DONE; otherwise go to CALC with counter=0.
- **CALC**
  - Restoring step, one quotient bit per cycle, MSB first.
  - Shift {rem, dvd} left by 1. If rem ≥ divisor, subtract the divisor and set quotient bit 1.
  - Subtractor width N_BITS+1.
  - After N_BITS steps (counter==N_BITS-1), go to FIX.
- **FIX**
  - Signed mode: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - Register `res_o`/`rem_q_o` according to `sel_rem_i`, then go to DONE.
- **DONE**
  - `valid_o`=1; outputs held stable.
  - On `pea_ready_i`=1 at the clock edge, go to IDLE.
- Special cases, results registered on the accept edge:
  - Divide by zero: quotient = all ones, remainder = dividend (both modes).
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- Inputs are sampled only at acceptance. Later operand changes and `ops_valid_i` pulses outside IDLE are ignored.
- `flush_i` takes priority over all transitions: next state IDLE, `valid_o`=0, result registers unchanged.
- Unsigned division with divisor > dividend: quotient 0, remainder = dividend, via the normal path.

## Timing
- Reset values: state IDLE, `ready_o`=1, `valid_o`=0, `res_o`=0, `rem_q_o`=0, counter 0.
- Operands accepted in cycle c (handshake true at the edge ending c):
  - CALC occupies cycles c+1 … c+N_BITS.
  - FIX occurs in cycle c+N_BITS+1.
  - `valid_o`=1 from cycle c+N_BITS+2.
- Special cases: `valid_o`=1 from cycle c+1.
- `valid_o` stays high until the edge at which `pea_ready_i`=1; it then drops and `ready_o` rises in the same following cycle.
- No acceptance during DONE, so the minimum initiation interval is N_BITS+3 cycles. Special cases: 2 cycles.
- `pea_ready_i` low does not stall CALC/FIX; it only holds DONE.
- `ready_o` and `valid_o` are decoded from registered state, with no combinational path from inputs.
- Reset asserted mid-operation clears everything immediately to the reset values.

## Structure
- In `pea_pkg`: `div_state_t` enum {IDLE, CALC, FIX, DONE}, plus constants `DIV_ZERO_Q` (all ones) and `DIV_OVF_Q` (MIN) parameterised by N_BITS.
- One natural sub-module: `div_step`, a combinational single restoring iteration.
  - Inputs: rem, dvd, divisor.
  - Outputs: next rem, next dvd, quotient bit.
  - Instantiated once.
- Everything else (FSM, counter, sign fix, output registers) lives in `s_div_unit`.

## Test plan
All scenarios use N_BITS=32.
- **Unsigned, quotient primary:** 100/7, `signed_i`=0, `sel_rem_i`=0, accepted cycle 0 → `valid_o` high at cycle 34, `res_o`=14, `rem_q_o`=2; `ready_o` returns 1 one cycle after `pea_ready_i` is sampled high.
- **Signed, remainder primary:** -7/2, `signed_i`=1, `sel_rem_i`=1 → `res_o`=0xFFFFFFFF (-1), `rem_q_o`=0xFFFFFFFD (-3).
- **Divide by zero:** 5/0, unsigned → `valid_o` at cycle 1; quotient 0xFFFFFFFF, remainder 5. Repeat with signed -5/0 → quotient 0xFFFFFFFF, remainder 0xFFFFFFFB.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF signed → `valid_o` at cycle 1; quotient 0x80000000, remainder 0.
- **Stall in DONE:** hold `pea_ready_i`=0 for 5 cycles in DONE while pulsing `ops_valid_i` with new operands → `valid_o`, `res_o`, `rem_q_o` held; `ready_o`=0; new operands not accepted. Then raise `pea_ready_i` → IDLE.
- **Abort mid-CALC:**
  - `flush_i` at cycle 10 of CALC → IDLE next cycle, `valid_o`=0, `ready_o`=1, previous results still on outputs.
  - Separately, `rst_n_i` low mid-CALC → immediate reset values.
